// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   seg_carry_t   : carry record produced by one lookahead segment
//   SEG_W_DEFAULT : default lookahead segment width
//   nseg()        : number of pipeline stages for a given width/segment
package adder_pkg;

  localparam int SEG_W_DEFAULT = 4;

  // Carry information of one segment. The segment sum travels in the
  // per-stage sum register; this record carries the two carries needed
  // downstream: cout feeds the next stage, c_msb (carry into the top bit)
  // combines with cout for signed overflow in the last segment.
  typedef struct packed {
    logic cout;
    logic c_msb;
  } seg_carry_t;

  function automatic int nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG_W-bit carry-lookahead segment.
//   a, b   : segment operands
//   cin    : carry into bit 0
//   sum    : segment sum
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (for signed overflow)
// Every internal carry is a flat sum of products over generate/propagate
// terms, so no carry ripples through another carry inside the segment.
module cla_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SEG_W-1:0] g;
  logic [SEG_W-1:0] p;
  logic [SEG_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = cin & p[0..i]  |  OR_j ( g[j] & p[j+1..i] )
  always_comb begin
    logic term;
    logic acc;
    term = 1'b0;
    acc  = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SEG_W; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      acc = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign sum   = p ^ c[SEG_W-1:0];
  assign cout  = c[SEG_W];
  assign c_msb = c[SEG_W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one register stage per
// SEG_W-bit segment (NSEG = WIDTH/SEG_W stages; WIDTH must be a multiple
// of SEG_W).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_a, in_b, in_sub  : operands; in_sub=1 computes A + ~B + 1
//   out_valid/out_ready : output handshake
//   out_sum, out_cout   : result mod 2^WIDTH, carry out of MSB
//   out_ovf             : signed overflow
//
// Handshake: a beat moves across an interface on a rising edge where
// valid && ready. valid never depends on ready; in_ready depends
// combinationally on out_ready through the per-stage load chain only.
// A stage loads when it is empty or when the stage after it loads/drains,
// so bubbles collapse and a full pipe holds NSEG beats. While out_valid is
// high and out_ready low the last stage does not load, so its outputs hold.
//
// Stage k holds the low (k+1)*SEG_W sum bits, the carry out of segment k,
// and only the operand bits not yet consumed.
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int SEG_W = SEG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  logic [WIDTH-1:0] b_eff;
  assign b_eff = in_sub ? ~in_b : in_b;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int HI = (k + 1) * SEG_W;

    logic             up_valid;
    logic [SEG_W-1:0] seg_a;
    logic [SEG_W-1:0] seg_b;
    logic             seg_cin;
    logic [SEG_W-1:0] seg_sum;
    logic [HI-1:0]    sum_next;
    seg_carry_t       seg_c;
    logic             seg_cout;
    logic             seg_c_msb;
    logic             load;
    logic             valid_q;
    logic [HI-1:0]    sum_q;
    logic             cout_q;

    if (k == 0) begin : g_src
      assign up_valid = in_valid;
      assign seg_a    = in_a[SEG_W-1:0];
      assign seg_b    = b_eff[SEG_W-1:0];
      assign seg_cin  = in_sub;
      assign sum_next = seg_sum;
    end else begin : g_src
      assign up_valid = g_stage[k-1].valid_q;
      assign seg_a    = g_stage[k-1].g_ops.a_rem[SEG_W-1:0];
      assign seg_b    = g_stage[k-1].g_ops.b_rem[SEG_W-1:0];
      assign seg_cin  = g_stage[k-1].cout_q;
      assign sum_next = {seg_sum, g_stage[k-1].sum_q};
    end

    cla_segment #(.SEG_W(SEG_W)) u_seg (
      .a     (seg_a),
      .b     (seg_b),
      .cin   (seg_cin),
      .sum   (seg_sum),
      .cout  (seg_cout),
      .c_msb (seg_c_msb)
    );

    assign seg_c = '{cout: seg_cout, c_msb: seg_c_msb};

    if (k == NSEG - 1) begin : g_load
      assign load = !valid_q || out_ready;
    end else begin : g_load
      assign load = !valid_q || g_stage[k+1].load;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        cout_q  <= 1'b0;
      end else if (load) begin
        valid_q <= up_valid;
        if (up_valid) begin
          sum_q  <= sum_next;
          cout_q <= seg_c.cout;
        end
      end
    end

    // Operand bits above this segment, still to be added downstream.
    if (k < NSEG - 1) begin : g_ops
      localparam int REM = WIDTH - HI;
      logic [REM-1:0] a_rem;
      logic [REM-1:0] b_rem;
      logic [REM-1:0] a_next;
      logic [REM-1:0] b_next;

      if (k == 0) begin : g_sel
        assign a_next = in_a[WIDTH-1:SEG_W];
        assign b_next = b_eff[WIDTH-1:SEG_W];
      end else begin : g_sel
        assign a_next = g_stage[k-1].g_ops.a_rem[REM+SEG_W-1:SEG_W];
        assign b_next = g_stage[k-1].g_ops.b_rem[REM+SEG_W-1:SEG_W];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_rem <= '0;
          b_rem <= '0;
        end else if (load && up_valid) begin
          a_rem <= a_next;
          b_rem <= b_next;
        end
      end
    end

    if (k == NSEG - 1) begin : g_last
      logic ovf_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (load && up_valid) begin
          ovf_q <= seg_c.cout ^ seg_c.c_msb;
        end
      end
    end
  end

  assign in_ready  = g_stage[0].load;
  assign out_valid = g_stage[NSEG-1].valid_q;
  assign out_sum   = g_stage[NSEG-1].sum_q;
  assign out_cout  = g_stage[NSEG-1].cout_q;
  assign out_ovf   = g_stage[NSEG-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT: WIDTH=12, SEG_W=4
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_a = '0;
  logic [11:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  // sweep DUTs: WIDTH=16/SEG_W=8 and WIDTH=8/SEG_W=8
  logic        s16_in_valid = 1'b0;
  logic        s16_in_ready;
  logic [15:0] s16_in_a = '0;
  logic [15:0] s16_in_b = '0;
  logic        s16_in_sub = 1'b0;
  logic        s16_out_valid;
  logic [15:0] s16_out_sum;
  logic        s16_out_cout;
  logic        s16_out_ovf;
  logic        s8_in_valid = 1'b0;
  logic        s8_in_ready;
  logic [7:0]  s8_in_a = '0;
  logic [7:0]  s8_in_b = '0;
  logic        s8_in_sub = 1'b0;
  logic        s8_out_valid;
  logic [7:0]  s8_out_sum;
  logic        s8_out_cout;
  logic        s8_out_ovf;
  logic        s_out_ready = 1'b1;

  pipelined_cla_adder #(.WIDTH(12), .SEG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  pipelined_cla_adder #(.WIDTH(16), .SEG_W(8)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(s16_in_valid), .in_ready(s16_in_ready),
    .in_a(s16_in_a), .in_b(s16_in_b), .in_sub(s16_in_sub),
    .out_valid(s16_out_valid), .out_ready(s_out_ready),
    .out_sum(s16_out_sum), .out_cout(s16_out_cout), .out_ovf(s16_out_ovf)
  );

  pipelined_cla_adder #(.WIDTH(8), .SEG_W(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(s8_in_valid), .in_ready(s8_in_ready),
    .in_a(s8_in_a), .in_b(s8_in_b), .in_sub(s8_in_sub),
    .out_valid(s8_out_valid), .out_ready(s_out_ready),
    .out_sum(s8_out_sum), .out_cout(s8_out_cout), .out_ovf(s8_out_ovf)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} for a w-bit add or subtract.
  function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic sub);
    logic [31:0] mask;
    logic [31:0] bb;
    logic [32:0] s;
    logic [31:0] sum;
    logic        cout;
    logic        sa;
    logic        sb;
    logic        ss;
    logic        ovf;
    mask = (32'h1 << w) - 32'h1;
    bb   = (sub ? ~b : b) & mask;
    s    = {1'b0, a & mask} + {1'b0, bb} + {32'b0, sub};
    sum  = s[31:0] & mask;
    cout = s[w];
    sa   = a[w-1];
    sb   = b[w-1];
    ss   = sum[w-1];
    ovf  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    return {ovf, cout, sum};
  endfunction

  // ---------------- scoreboards ----------------
  logic [33:0] exp_q[$];
  logic [33:0] exp16_q[$];
  logic [33:0] exp8_q[$];

  always @(negedge clk) begin
    logic have;
    if (rst) begin
      exp_q.delete();
      exp16_q.delete();
      exp8_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        have = exp_q.size() != 0;
        check("main_expected_pending", {33'b0, have}, 34'd1);
        if (have) check("main_result", {out_ovf, out_cout, 20'b0, out_sum}, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(12, {20'b0, in_a}, {20'b0, in_b}, in_sub));

      if (s16_out_valid && s_out_ready) begin
        have = exp16_q.size() != 0;
        check("w16_expected_pending", {33'b0, have}, 34'd1);
        if (have) check("w16_result", {s16_out_ovf, s16_out_cout, 16'b0, s16_out_sum}, exp16_q.pop_front());
      end
      if (s16_in_valid && s16_in_ready) exp16_q.push_back(model(16, {16'b0, s16_in_a}, {16'b0, s16_in_b}, s16_in_sub));

      if (s8_out_valid && s_out_ready) begin
        have = exp8_q.size() != 0;
        check("w8_expected_pending", {33'b0, have}, 34'd1);
        if (have) check("w8_result", {s8_out_ovf, s8_out_cout, 24'b0, s8_out_sum}, exp8_q.pop_front());
      end
      if (s8_in_valid && s8_in_ready) exp8_q.push_back(model(8, {24'b0, s8_in_a}, {24'b0, s8_in_b}, s8_in_sub));
    end
  end

  // ---------------- driver tasks ----------------
  // One beat into an empty pipe; checks accept, latency and the result.
  task automatic run_one(input string tag, input logic [11:0] a, input logic [11:0] b,
                         input logic sub, input logic [11:0] es, input logic ec, input logic eo);
    int lat;
    @(posedge clk);
    #1;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, {33'b0, in_ready}, 34'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 34'(lat), 34'd3);
    check({tag, "_value"}, {out_ovf, out_cout, 20'b0, out_sum}, {eo, ec, 20'b0, es});
  endtask

  task automatic wait_drain(input string tag);
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || exp16_q.size() != 0 || exp8_q.size() != 0) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_main_drained"}, 34'(exp_q.size()), 34'd0);
    check({tag, "_sweep_drained"}, 34'(exp16_q.size() + exp8_q.size()), 34'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic        took;
    logic [33:0] stall_val;
    int          acc;
    int          cyc;
    int          cnt;
    int          first_i;
    int          last_i;
    int          lat16;
    int          lat8;

    // reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {33'b0, out_valid}, 34'd0);
    check("rst_out_sum", {22'b0, out_sum}, 34'd0);
    check("rst_flags", {32'b0, out_cout, out_ovf}, 34'd0);
    check("rst_in_ready", {33'b0, in_ready}, 34'd1);

    // add / wrap / overflow / subtract
    run_one("add_5_7", 12'd5, 12'd7, 1'b0, 12'd12, 1'b0, 1'b0);
    run_one("wrap_4095_1", 12'd4095, 12'd1, 1'b0, 12'd0, 1'b1, 1'b0);
    run_one("ovf_2047_1", 12'd2047, 12'd1, 1'b0, 12'd2048, 1'b0, 1'b1);
    run_one("sub_50_75", 12'd50, 12'd75, 1'b1, 12'hFE7, 1'b0, 1'b0);
    run_one("sub_1000_500", 12'd1000, 12'd500, 1'b1, 12'd500, 1'b1, 1'b0);
    wait_drain("directed");

    // backpressure: 10 beats, out_ready low for the first 6 cycles
    acc = 0;
    cyc = 0;
    took = 1'b0;
    stall_val = '0;
    in_a = 12'($urandom_range(0, 4095));
    in_b = 12'($urandom_range(0, 4095));
    in_sub = 1'($urandom_range(0, 1));
    while (cyc < 100) begin
      @(posedge clk);
      if (took) acc++;
      if (acc >= 10) break;
      #1;
      if (took) begin
        in_a = 12'($urandom_range(0, 4095));
        in_b = 12'($urandom_range(0, 4095));
        in_sub = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b1;
      out_ready = (cyc >= 6);
      @(negedge clk);
      if (cyc == 3) begin
        check("bp_accepts_when_full", 34'(acc), 34'd3);
        check("bp_in_ready_full", {33'b0, in_ready}, 34'd0);
        check("bp_out_valid_full", {33'b0, out_valid}, 34'd1);
        stall_val = {out_ovf, out_cout, 20'b0, out_sum};
      end
      if (cyc == 4 || cyc == 5) begin
        check("bp_stall_stable", {out_ovf, out_cout, 20'b0, out_sum}, stall_val);
        check("bp_in_ready_stall", {33'b0, in_ready}, 34'd0);
      end
      took = in_ready;
      cyc++;
    end
    check("bp_all_accepted", 34'(acc), 34'd10);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("backpressure");

    // bubbles: in_valid toggles, out_ready random
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      in_a = 12'($urandom_range(0, 4095));
      in_b = 12'($urandom_range(0, 4095));
      in_sub = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("bubbles");

    // throughput: 8 back-to-back beats must emerge back-to-back
    cnt = 0;
    first_i = -1;
    last_i = -1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i < 8);
      in_a = 12'($urandom_range(0, 4095));
      in_b = 12'($urandom_range(0, 4095));
      in_sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid) begin
        cnt++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
    end
    check("tput_out_count", 34'(cnt), 34'd8);
    check("tput_no_gap", 34'(last_i - first_i + 1), 34'd8);
    check("tput_first_out", 34'(first_i), 34'd3);
    wait_drain("throughput");

    // reset with two beats in flight
    @(posedge clk);
    #1;
    in_a = 12'd100; in_b = 12'd200; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_a = 12'd300; in_b = 12'd1; in_sub = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", {33'b0, out_valid}, 34'd0);
    repeat (6) @(negedge clk);
    run_one("after_rst_3_4", 12'd3, 12'd4, 1'b0, 12'd7, 1'b0, 1'b0);
    wait_drain("reset");

    // parameter sweep: latency of one beat
    @(posedge clk);
    #1;
    s16_in_a = 16'd40000; s16_in_b = 16'd30000; s16_in_sub = 1'b0; s16_in_valid = 1'b1;
    s8_in_a = 8'd100; s8_in_b = 8'd200; s8_in_sub = 1'b1; s8_in_valid = 1'b1;
    @(negedge clk);
    check("sweep_in_ready", {32'b0, s16_in_ready, s8_in_ready}, 34'd3);
    @(posedge clk);
    #1;
    s16_in_valid = 1'b0;
    s8_in_valid = 1'b0;
    @(negedge clk);
    lat16 = 0;
    lat8 = 0;
    for (int c = 1; c <= 20; c++) begin
      if (lat16 == 0 && s16_out_valid) lat16 = c;
      if (lat8 == 0 && s8_out_valid) lat8 = c;
      if (lat16 != 0 && lat8 != 0) break;
      @(posedge clk);
      @(negedge clk);
    end
    check("w16_latency", 34'(lat16), 34'd2);
    check("w8_latency", 34'(lat8), 34'd1);

    // parameter sweep: 1000 random add/sub beats
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      s16_in_valid = 1'b1;
      s16_in_a = 16'($urandom_range(0, 65535));
      s16_in_b = 16'($urandom_range(0, 65535));
      s16_in_sub = 1'($urandom_range(0, 1));
      s8_in_valid = 1'b1;
      s8_in_a = 8'($urandom_range(0, 255));
      s8_in_b = 8'($urandom_range(0, 255));
      s8_in_sub = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    s16_in_valid = 1'b0;
    s8_in_valid = 1'b0;
    wait_drain("sweep");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
